// File: rtl/gravsim_regbank_if.sv
// gravsim_regbank_if
//   Bus bundle between the gravity-simulator register bank and its two
//   masters: the Nios II Avalon-MM slave port and the single-port physics
//   engine access channel.
// Signals:
//   AVL_CS/AVL_READ/AVL_WRITE, AVL_BYTE_EN[3:0], AVL_ADDR, AVL_WRITEDATA -> bank
//   AVL_READDATA                                                          <- bank
//   ENG_REQ/ENG_WE, ENG_ADDR, ENG_WDATA                                   -> bank
//   ENG_ACK, ENG_RDATA                                                    <- bank
// Modports: slave (register bank), master (Nios II / engine side).
interface gravsim_regbank_if #(
  parameter int ADDR_W = 8
);
  logic              AVL_CS;
  logic              AVL_READ;
  logic              AVL_WRITE;
  logic [3:0]        AVL_BYTE_EN;
  logic [ADDR_W-1:0] AVL_ADDR;
  logic [31:0]       AVL_WRITEDATA;
  logic [31:0]       AVL_READDATA;
  logic              ENG_REQ;
  logic              ENG_WE;
  logic [ADDR_W-1:0] ENG_ADDR;
  logic [31:0]       ENG_WDATA;
  logic              ENG_ACK;
  logic [31:0]       ENG_RDATA;

  modport slave (
    input  AVL_CS, AVL_READ, AVL_WRITE, AVL_BYTE_EN, AVL_ADDR, AVL_WRITEDATA,
    output AVL_READDATA,
    input  ENG_REQ, ENG_WE, ENG_ADDR, ENG_WDATA,
    output ENG_ACK, ENG_RDATA
  );

  modport master (
    output AVL_CS, AVL_READ, AVL_WRITE, AVL_BYTE_EN, AVL_ADDR, AVL_WRITEDATA,
    input  AVL_READDATA,
    output ENG_REQ, ENG_WE, ENG_ADDR, ENG_WDATA,
    input  ENG_ACK, ENG_RDATA
  );
endinterface

// File: rtl/gravsim_regbank.sv
// gravsim_regbank
//   Register bank for the gravity simulator: global constants plus per-body
//   mass/radius/position/velocity/acceleration words. Arbitrates the engine
//   access channel against Avalon writes, issues FRAME_START on vsync, owns
//   the SPACE pause toggle and the camera-shift offsets.
// Ports:
//   CLK, RESET          clock, asynchronous active-high reset
//   bus (slave)         Avalon-MM slave + engine request/ack channel
//   ENG_CLR_ACC         clear every acceleration word
//   ENG_DONE            engine finished the frame (sets STATUS.done)
//   FRAME_START         one-cycle start pulse to the engine
//   VGA_VS              vsync, rising edge = frame tick
//   keycode             current USB HID key
//   BODY_RAD/POS_*      flattened body geometry, body i at [32i+31:32i]
//   CAM_SHIFT_*         signed camera offsets
//   EXPORT_DATA         {keycode, 7'b0, paused, frame_count}
// Build option: define GRAVSIM_CAMERA_EN to enable the camera-shift logic;
//   otherwise CAM_SHIFT_* are 0 and direction keys are ignored.
//
// Engine port FSM
//   state   | meaning
//   ST_IDLE | waiting for ENG_REQ with no Avalon write in the same cycle
//   ST_ACK  | access performed last cycle, ENG_ACK asserted
module gravsim_regbank #(
  parameter int NUM_BODIES = 4,
  parameter int ADDR_W     = 8,
  parameter int CAM_STEP   = 1,
  parameter int KEY_SPACE  = 44,
  parameter int KEY_UP     = 26,
  parameter int KEY_DOWN   = 22,
  parameter int KEY_LEFT   = 4,
  parameter int KEY_RIGHT  = 7,
  parameter int KEY_PGUP   = 75,
  parameter int KEY_PGDN   = 78
) (
  input  logic                    CLK,
  input  logic                    RESET,
  gravsim_regbank_if.slave        bus,
  input  logic                    ENG_CLR_ACC,
  input  logic                    ENG_DONE,
  output logic                    FRAME_START,
  input  logic                    VGA_VS,
  input  logic [7:0]              keycode,
  output logic [32*NUM_BODIES-1:0] BODY_RAD,
  output logic [32*NUM_BODIES-1:0] BODY_POS_X,
  output logic [32*NUM_BODIES-1:0] BODY_POS_Y,
  output logic [32*NUM_BODIES-1:0] BODY_POS_Z,
  output logic [31:0]             CAM_SHIFT_X,
  output logic [31:0]             CAM_SHIFT_Y,
  output logic [31:0]             CAM_SHIFT_Z,
  output logic [31:0]             EXPORT_DATA
);
  localparam int BASE      = 4;
  localparam int NUM_WORDS = 11 * NUM_BODIES;
  localparam int ACC_FIRST = 8 * NUM_BODIES;

  typedef enum logic {ST_IDLE, ST_ACK} eng_state_t;

  eng_state_t  state_q, state_d;
  logic        eng_accept;
  logic [31:0] g_q, ready_q;
  logic        done_q, paused_q;
  logic [31:0] body_q [NUM_WORDS];
  logic [31:0] avl_rdata_q, eng_rdata_q;
  logic [15:0] frame_cnt_q;
  logic        vs_s1_q, vs_s2_q, vs_s3_q;
  logic [7:0]  key_q;

  wire avl_wr    = bus.AVL_CS & bus.AVL_WRITE;
  wire avl_rd    = bus.AVL_CS & bus.AVL_READ;
  wire eng_wr    = eng_accept & bus.ENG_WE;
  wire eng_rd    = eng_accept & ~bus.ENG_WE;
  wire vs_rise   = vs_s2_q & ~vs_s3_q;
  wire frame_go  = vs_rise & ready_q[0] & ~paused_q;
  wire space_hit = (keycode == 8'(KEY_SPACE)) && (key_q != 8'(KEY_SPACE));

  // Only a written 0 in bit 0 clears done; a written 1 leaves it alone.
  wire status_clr = (avl_wr && bus.AVL_ADDR == ADDR_W'(3) && bus.AVL_BYTE_EN[0]
                     && !bus.AVL_WRITEDATA[0])
                  || (eng_wr && bus.ENG_ADDR == ADDR_W'(3) && !bus.ENG_WDATA[0]);

  function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rd_word(input logic [ADDR_W-1:0] a);
    logic [31:0] r;
    r = '0;
    if (a == ADDR_W'(0))      r = g_q;
    else if (a == ADDR_W'(1)) r = 32'(NUM_BODIES);
    else if (a == ADDR_W'(2)) r = ready_q;
    else if (a == ADDR_W'(3)) r = {30'd0, paused_q, done_q};
    for (int k = 0; k < NUM_WORDS; k++)
      if (a == ADDR_W'(BASE + k)) r = body_q[k];
    return r;
  endfunction

  // Engine port FSM
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    eng_accept = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.ENG_REQ && !avl_wr) begin
        eng_accept = 1'b1;
        state_d    = ST_ACK;
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.ENG_ACK      = (state_q == ST_ACK);
  assign bus.ENG_RDATA    = eng_rdata_q;
  assign bus.AVL_READDATA = avl_rdata_q;

  // Register file and read ports
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      g_q         <= '0;
      ready_q     <= '0;
      avl_rdata_q <= '0;
      eng_rdata_q <= '0;
      for (int k = 0; k < NUM_WORDS; k++) body_q[k] <= '0;
    end else begin
      avl_rdata_q <= avl_rd ? rd_word(bus.AVL_ADDR) : 32'd0;
      if (eng_rd) eng_rdata_q <= rd_word(bus.ENG_ADDR);

      if (avl_wr && bus.AVL_ADDR == ADDR_W'(0))
        g_q <= be_merge(g_q, bus.AVL_WRITEDATA, bus.AVL_BYTE_EN);
      else if (eng_wr && bus.ENG_ADDR == ADDR_W'(0))
        g_q <= bus.ENG_WDATA;

      if (avl_wr && bus.AVL_ADDR == ADDR_W'(2))
        ready_q <= be_merge(ready_q, bus.AVL_WRITEDATA, bus.AVL_BYTE_EN);
      else if (eng_wr && bus.ENG_ADDR == ADDR_W'(2))
        ready_q <= bus.ENG_WDATA;

      // Priority per word: Avalon write, then engine write, then ACC clear.
      for (int k = 0; k < NUM_WORDS; k++) begin
        if (avl_wr && bus.AVL_ADDR == ADDR_W'(BASE + k))
          body_q[k] <= be_merge(body_q[k], bus.AVL_WRITEDATA, bus.AVL_BYTE_EN);
        else if (eng_wr && bus.ENG_ADDR == ADDR_W'(BASE + k))
          body_q[k] <= bus.ENG_WDATA;
        else if (ENG_CLR_ACC && k >= ACC_FIRST)
          body_q[k] <= '0;
      end
    end
  end

  // Frame tick, status and pause
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      vs_s1_q     <= 1'b0;
      vs_s2_q     <= 1'b0;
      vs_s3_q     <= 1'b0;
      FRAME_START <= 1'b0;
      frame_cnt_q <= '0;
      done_q      <= 1'b0;
      paused_q    <= 1'b0;
      key_q       <= '0;
    end else begin
      vs_s1_q     <= VGA_VS;
      vs_s2_q     <= vs_s1_q;
      vs_s3_q     <= vs_s2_q;
      FRAME_START <= frame_go;
      key_q       <= keycode;
      if (frame_go) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (ENG_DONE)                     done_q <= 1'b1;
      else if (frame_go || status_clr) done_q <= 1'b0;
      if (space_hit) paused_q <= ~paused_q;
    end
  end

`ifdef GRAVSIM_CAMERA_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      CAM_SHIFT_X <= '0;
      CAM_SHIFT_Y <= '0;
      CAM_SHIFT_Z <= '0;
    end else if (vs_rise) begin
      if (keycode == 8'(KEY_UP))         CAM_SHIFT_Y <= CAM_SHIFT_Y - 32'(CAM_STEP);
      else if (keycode == 8'(KEY_DOWN))  CAM_SHIFT_Y <= CAM_SHIFT_Y + 32'(CAM_STEP);
      else if (keycode == 8'(KEY_LEFT))  CAM_SHIFT_X <= CAM_SHIFT_X - 32'(CAM_STEP);
      else if (keycode == 8'(KEY_RIGHT)) CAM_SHIFT_X <= CAM_SHIFT_X + 32'(CAM_STEP);
      else if (keycode == 8'(KEY_PGUP))  CAM_SHIFT_Z <= CAM_SHIFT_Z + 32'(CAM_STEP);
      else if (keycode == 8'(KEY_PGDN))  CAM_SHIFT_Z <= CAM_SHIFT_Z - 32'(CAM_STEP);
    end
  end
`else
  assign CAM_SHIFT_X = '0;
  assign CAM_SHIFT_Y = '0;
  assign CAM_SHIFT_Z = '0;
  // Direction keys and step have no effect in this build.
  wire unused_cam_keys = (keycode == 8'(KEY_UP))   | (keycode == 8'(KEY_DOWN))
                       | (keycode == 8'(KEY_LEFT)) | (keycode == 8'(KEY_RIGHT))
                       | (keycode == 8'(KEY_PGUP)) | (keycode == 8'(KEY_PGDN))
                       | (CAM_STEP != 0);
`endif

  for (genvar i = 0; i < NUM_BODIES; i++) begin : g_export
    assign BODY_RAD[32*i +: 32]   = body_q[1*NUM_BODIES + i];
    assign BODY_POS_X[32*i +: 32] = body_q[2*NUM_BODIES + i];
    assign BODY_POS_Y[32*i +: 32] = body_q[3*NUM_BODIES + i];
    assign BODY_POS_Z[32*i +: 32] = body_q[4*NUM_BODIES + i];
  end

  assign EXPORT_DATA = {keycode, 7'd0, paused_q, frame_cnt_q};
endmodule

// File: tb/tb_gravsim_regbank.sv
module tb_gravsim_regbank;
  logic         clk = 1'b0;
  logic         rst;
  logic         eng_clr_acc, eng_done, frame_start, vga_vs;
  logic [7:0]   keycode;
  logic [127:0] body_rad, body_pos_x, body_pos_y, body_pos_z;
  logic [31:0]  cam_x, cam_y, cam_z, export_data;
  int           n_asserts = 0;
  int           n_fail = 0;
  int           np, fp, lat;

`ifdef GRAVSIM_CAMERA_EN
  localparam bit CAM_ON = 1'b1;
`else
  localparam bit CAM_ON = 1'b0;
`endif

  gravsim_regbank_if #(.ADDR_W(8)) bus ();

  gravsim_regbank #(.NUM_BODIES(4), .ADDR_W(8)) dut (
    .CLK(clk), .RESET(rst), .bus(bus),
    .ENG_CLR_ACC(eng_clr_acc), .ENG_DONE(eng_done), .FRAME_START(frame_start),
    .VGA_VS(vga_vs), .keycode(keycode),
    .BODY_RAD(body_rad), .BODY_POS_X(body_pos_x), .BODY_POS_Y(body_pos_y),
    .BODY_POS_Z(body_pos_z),
    .CAM_SHIFT_X(cam_x), .CAM_SHIFT_Y(cam_y), .CAM_SHIFT_Z(cam_z),
    .EXPORT_DATA(export_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic avl_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    bus.AVL_CS = 1'b1; bus.AVL_WRITE = 1'b1; bus.AVL_ADDR = a;
    bus.AVL_WRITEDATA = d; bus.AVL_BYTE_EN = be;
    tick();
    bus.AVL_CS = 1'b0; bus.AVL_WRITE = 1'b0; bus.AVL_BYTE_EN = 4'h0;
  endtask

  task automatic avl_read(input string tag, input logic [7:0] a, input logic [31:0] exp);
    bus.AVL_CS = 1'b1; bus.AVL_READ = 1'b1; bus.AVL_ADDR = a;
    tick();
    bus.AVL_CS = 1'b0; bus.AVL_READ = 1'b0;
    check(tag, bus.AVL_READDATA, exp);
  endtask

  // Issues one engine access and waits (bounded) for ENG_ACK.
  task automatic eng_access(input string tag, input logic we, input logic [7:0] a,
                            input logic [31:0] d, input logic [31:0] exp_rd);
    int n;
    bus.ENG_REQ = 1'b1; bus.ENG_WE = we; bus.ENG_ADDR = a; bus.ENG_WDATA = d;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.ENG_ACK && n < 10);
    bus.ENG_REQ = 1'b0;
    check({tag, "_lat"}, 32'(n), 32'd1);
    if (!we) check({tag, "_rdata"}, bus.ENG_RDATA, exp_rd);
    tick();
  endtask

  // Holds VGA_VS high for 6 cycles; reports pulse count and cycle of first pulse.
  task automatic vs_pulse(output int n, output int first);
    vga_vs = 1'b1;
    n = 0; first = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (frame_start) begin
        n++;
        if (first == 0) first = i;
      end
    end
    vga_vs = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    rst = 1'b1; eng_clr_acc = 1'b0; eng_done = 1'b0; vga_vs = 1'b0; keycode = 8'd0;
    bus.AVL_CS = 1'b0; bus.AVL_READ = 1'b0; bus.AVL_WRITE = 1'b0; bus.AVL_BYTE_EN = 4'h0;
    bus.AVL_ADDR = 8'd0; bus.AVL_WRITEDATA = 32'd0;
    bus.ENG_REQ = 1'b0; bus.ENG_WE = 1'b0; bus.ENG_ADDR = 8'd0; bus.ENG_WDATA = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Reset state
    check("rst_eng_ack", 32'(bus.ENG_ACK), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_readdata", bus.AVL_READDATA, 32'd0);
    check("rst_export", export_data, 32'd0);
    check("rst_cam_x", cam_x, 32'd0);
    avl_read("rd_num", 8'd1, 32'h4);
    avl_read("rd_g", 8'd0, 32'h0);
    avl_read("rd_status_rst", 8'd3, 32'h0);

    // Out of range
    avl_write(8'd48, 32'hFFFF_FFFF, 4'hF);
    avl_read("rd_oob", 8'd48, 32'h0);
    avl_read("rd_last_word", 8'd47, 32'h0);

    // Byte enables
    avl_write(8'd13, 32'hAABB_CCDD, 4'b0101);
    check("posx_b1_export", body_pos_x[63:32], 32'h00BB_00DD);
    avl_read("rd_posx_b1", 8'd13, 32'h00BB_00DD);
    tick();
    check("readdata_idle_zero", bus.AVL_READDATA, 32'h0);
    avl_write(8'd0, 32'h1234_5678, 4'b1000);
    avl_read("rd_g_be", 8'd0, 32'h1200_0000);

    // Avalon write and engine write to the same word in the same cycle
    bus.AVL_CS = 1'b1; bus.AVL_WRITE = 1'b1; bus.AVL_ADDR = 8'd5;
    bus.AVL_WRITEDATA = 32'h11; bus.AVL_BYTE_EN = 4'hF;
    bus.ENG_REQ = 1'b1; bus.ENG_WE = 1'b1; bus.ENG_ADDR = 8'd5; bus.ENG_WDATA = 32'hCAFE_F00D;
    tick();
    bus.AVL_CS = 1'b0; bus.AVL_WRITE = 1'b0; bus.AVL_BYTE_EN = 4'h0;
    check("eng_stall_no_ack", 32'(bus.ENG_ACK), 32'd0);
    tick();
    check("eng_ack_after_stall", 32'(bus.ENG_ACK), 32'd1);
    bus.ENG_REQ = 1'b0;
    tick();
    check("eng_ack_single", 32'(bus.ENG_ACK), 32'd0);
    avl_read("rd_collide", 8'd5, 32'hCAFE_F00D);

    // Plain engine accesses
    eng_access("eng_wr_rad", 1'b1, 8'd9, 32'h1234_5678, 32'h0);
    check("rad_b1_export", body_rad[63:32], 32'h1234_5678);
    eng_access("eng_rd_posx", 1'b0, 8'd13, 32'h0, 32'h00BB_00DD);
    eng_access("eng_wr_num", 1'b1, 8'd1, 32'hDEAD_BEEF, 32'h0);
    avl_read("rd_num_ro", 8'd1, 32'h4);

    // ACC clear, coincident with an Avalon write to one ACC word
    for (int k = 36; k < 48; k++) avl_write(8'(k), 32'h5, 4'hF);
    avl_read("rd_acc_pre", 8'd41, 32'h5);
    bus.AVL_CS = 1'b1; bus.AVL_WRITE = 1'b1; bus.AVL_ADDR = 8'd36;
    bus.AVL_WRITEDATA = 32'h77; bus.AVL_BYTE_EN = 4'hF;
    eng_clr_acc = 1'b1;
    tick();
    bus.AVL_CS = 1'b0; bus.AVL_WRITE = 1'b0; bus.AVL_BYTE_EN = 4'h0;
    eng_clr_acc = 1'b0;
    avl_read("rd_acc_avl_win", 8'd36, 32'h77);
    avl_read("rd_acc_clr_41", 8'd41, 32'h0);
    avl_read("rd_acc_clr_47", 8'd47, 32'h0);
    avl_read("rd_posx_kept", 8'd13, 32'h00BB_00DD);

    // Frame ticks
    vs_pulse(np, fp);
    check("no_frame_not_ready", 32'(np), 32'd0);
    avl_write(8'd2, 32'h1, 4'hF);
    vs_pulse(np, fp);
    check("frame1_pulses", 32'(np), 32'd1);
    check("frame1_latency", 32'(fp), 32'd3);
    vs_pulse(np, fp);
    check("frame2_pulses", 32'(np), 32'd1);
    check("frame_count_2", export_data, 32'd2);

    // Done handling
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    avl_read("status_done", 8'd3, 32'h1);
    vs_pulse(np, fp);
    avl_read("status_done_clr", 8'd3, 32'h0);
    vga_vs = 1'b1;
    tick();
    tick();
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    check("coinc_frame_start", 32'(frame_start), 32'd1);
    vga_vs = 1'b0;
    repeat (4) tick();
    avl_read("coinc_done_set", 8'd3, 32'h1);

    // Pause
    keycode = 8'd44;
    repeat (10) tick();
    check("paused_export", export_data, {8'd44, 7'd0, 1'b1, 16'd4});
    vs_pulse(np, fp);
    check("paused_no_pulse", 32'(np), 32'd0);
    avl_write(8'd3, 32'h0, 4'hF);
    avl_read("status_paused", 8'd3, 32'h2);
    keycode = 8'd0;
    tick();
    keycode = 8'd44;
    tick();
    keycode = 8'd0;
    avl_read("status_unpaused", 8'd3, 32'h0);

    // Camera
    keycode = 8'd4;
    vga_vs = 1'b1;
    tick();
    tick();
    check("cam_x_before_tick", cam_x, 32'h0);
    tick();
    check("cam_frame_start", 32'(frame_start), 32'd1);
    check("cam_x_with_tick", cam_x, CAM_ON ? 32'hFFFF_FFFF : 32'h0);
    vga_vs = 1'b0;
    repeat (3) tick();
    vs_pulse(np, fp);
    vs_pulse(np, fp);
    check("cam_x_left3", cam_x, CAM_ON ? 32'hFFFF_FFFD : 32'h0);
    keycode = 8'd26;
    vs_pulse(np, fp);
    check("cam_y_up", cam_y, CAM_ON ? 32'hFFFF_FFFF : 32'h0);
    keycode = 8'd75;
    vs_pulse(np, fp);
    check("cam_z_pgup", cam_z, CAM_ON ? 32'h1 : 32'h0);
    keycode = 8'd0;
    tick();
    check("frame_count_9", export_data, 32'd9);

    // Reset in the middle of an engine access
    bus.ENG_REQ = 1'b1; bus.ENG_WE = 1'b0; bus.ENG_ADDR = 8'd13;
    #2 rst = 1'b1;
    #1 check("midrst_no_ack", 32'(bus.ENG_ACK), 32'd0);
    tick();
    tick();
    check("midrst_no_ack_held", 32'(bus.ENG_ACK), 32'd0);
    bus.ENG_REQ = 1'b0;
    rst = 1'b0;
    tick();
    check("midrst_ack_after", 32'(bus.ENG_ACK), 32'd0);
    check("midrst_rdata", bus.ENG_RDATA, 32'h0);
    check("midrst_export", export_data, 32'h0);
    check("midrst_cam_x", cam_x, 32'h0);
    check("midrst_posx", body_pos_x[63:32], 32'h0);
    avl_read("midrst_rd_ready", 8'd2, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
